// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : term_pkg
//  Purpose  : Shared types and constants for the terminal controller that
//             feeds vga_text_mode: FSM state encoding, control-code values,
//             blank-cell index, screen size and the display request record.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package term_pkg;

    // Controller states; explicit 4-bit encoding.
    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_IDLE     = 4'd1,
        ST_PUT      = 4'd2,
        ST_ADV      = 4'd3,
        ST_NEWLINE  = 4'd4,
        ST_SCROLL   = 4'd5,
        ST_CLR_ROW  = 4'd6,
        ST_CLR_ALL  = 4'd7,
        ST_WAIT     = 4'd8
    } state_t;

    // Control codes interpreted from the byte stream.
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_FF = 8'h0C;

    // Stored index of a blank cell: space (0x20) plus the display's +1 bias.
    localparam logic [7:0] BLANK_IDX    = 8'h21;
    localparam int         SCREEN_CELLS = 2000;

    // One display request: cell range [first, last), fill index, copy offset.
    typedef struct packed {
        logic [10:0] first;
        logic [10:0] last;
        logic [7:0]  data;
        logic [7:0]  offset;
    } wr_req_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/term_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : term_ctrl
//  Purpose  : Byte-stream terminal front end for vga_text_mode. Tracks an
//             COLS x ROWS cursor, interprets CR/LF/BS/FF, and issues write,
//             scroll (copy) and clear (fill) requests on the wr_* interface.
//  Ports    : clk100      - system clock
//             rst         - synchronous reset, active-high
//             in_valid    - input byte valid
//             in_data     - input byte
//             in_ready    - byte accepted when in_valid & in_ready
//             wr_start    - one-cycle request pulse
//             wr_begin    - first cell address of the request
//             wr_end      - one past the last cell address
//             wr_data     - fill index (used when wr_offset == 0)
//             wr_offset   - copy source offset; 0 selects a fill
//             wr_complete - one-cycle pulse: current request finished
//             cursor_col  - current column
//             cursor_row  - current row
//             busy        - high whenever the controller is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module term_ctrl
    import term_pkg::*;
#(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter int         INIT_WAIT = 8192,
    parameter logic [7:0] BLANK_IDX = term_pkg::BLANK_IDX
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_start,
    output logic [10:0] wr_begin,
    output logic [10:0] wr_end,
    output logic [7:0]  wr_data,
    output logic [7:0]  wr_offset,
    input  logic        wr_complete,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam int          c_cnt_w    = $clog2(INIT_WAIT + 1);
    localparam logic [10:0] c_cells    = 11'(COLS * ROWS);
    localparam logic [10:0] c_last_row = 11'((ROWS - 1) * COLS);
    localparam logic [6:0]  c_col_max  = 7'(COLS - 1);
    localparam logic [4:0]  c_row_max  = 5'(ROWS - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(INIT_WAIT - 1);

    state_t             r_state;
    state_t             r_next;       // action taken once WAIT sees wr_complete
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [6:0]         r_col;
    logic [4:0]         r_row;
    logic               r_in_ready;
    logic               r_wr_start;
    wr_req_t            r_req;

    logic [10:0]        w_row_base;
    logic [10:0]        w_addr;
    logic               w_accept;
    wr_req_t            w_put_req;
    wr_req_t            w_scroll_req;
    wr_req_t            w_clr_row_req;
    wr_req_t            w_clr_all_req;

    // Row base address. For the standard 80-column screen this is the
    // shift-add form row*64 + row*16; other widths fall back to a constant
    // multiply.
    generate
        if (COLS == 80) begin : g_row_base_shift
            assign w_row_base = ({6'd0, r_row} << 6) + ({6'd0, r_row} << 4);
        end else begin : g_row_base_mult
            assign w_row_base = 11'(r_row * COLS);
        end
    endgenerate

    assign w_addr   = w_row_base + {4'd0, r_col};
    assign w_accept = in_valid & r_in_ready;

    // Request templates. The display subtracts 1 from the stored index, so a
    // character is written as byte + 1.
    assign w_put_req     = '{first: w_addr, last: w_addr + 11'd1,
                             data: in_data + 8'd1, offset: 8'd0};
    assign w_scroll_req  = '{first: 11'd0, last: c_last_row,
                             data: BLANK_IDX, offset: 8'(COLS)};
    assign w_clr_row_req = '{first: c_last_row, last: c_cells,
                             data: BLANK_IDX, offset: 8'd0};
    assign w_clr_all_req = '{first: 11'd0, last: c_cells,
                             data: BLANK_IDX, offset: 8'd0};

    // Request fields are loaded on the edge that enters a request state, so
    // wr_start and the fields are valid together in that state's only cycle.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_next     <= ST_IDLE;
            r_wait_cnt <= '0;
            r_col      <= 7'd0;
            r_row      <= 5'd0;
            r_in_ready <= 1'b0;
            r_wr_start <= 1'b0;
            r_req      <= '0;
        end else begin
            r_wr_start <= 1'b0;
            case (r_state)
                // The display has no reset and may still be finishing a
                // request from before our reset, so complete pulses are
                // ignored until the full wait has elapsed.
                ST_INIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_state    <= ST_CLR_ALL;
                        r_req      <= w_clr_all_req;
                        r_wr_start <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_printable(in_data)) begin
                            r_state    <= ST_PUT;
                            r_req      <= w_put_req;
                            r_wr_start <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            case (in_data)
                                CHAR_CR: r_col <= 7'd0;
                                CHAR_LF: begin
                                    r_state    <= ST_NEWLINE;
                                    r_in_ready <= 1'b0;
                                end
                                CHAR_BS: begin
                                    if (r_col != 7'd0) r_col <= r_col - 7'd1;
                                end
                                CHAR_FF: begin
                                    r_state    <= ST_CLR_ALL;
                                    r_req      <= w_clr_all_req;
                                    r_wr_start <= 1'b1;
                                    r_in_ready <= 1'b0;
                                end
                                default: ;  // unsupported codes are dropped
                            endcase
                        end
                    end
                end

                ST_PUT: begin
                    r_state <= ST_WAIT;
                    r_next  <= ST_ADV;
                end

                ST_SCROLL: begin
                    r_state <= ST_WAIT;
                    r_next  <= ST_CLR_ROW;
                end

                ST_CLR_ROW: begin
                    r_state <= ST_WAIT;
                    r_next  <= ST_IDLE;
                end

                ST_CLR_ALL: begin
                    r_col   <= 7'd0;
                    r_row   <= 5'd0;
                    r_state <= ST_WAIT;
                    r_next  <= ST_IDLE;
                end

                ST_WAIT: begin
                    if (wr_complete) begin
                        r_state <= r_next;
                        // The bottom-row clear follows a scroll directly.
                        if (r_next == ST_CLR_ROW) begin
                            r_req      <= w_clr_row_req;
                            r_wr_start <= 1'b1;
                        end
                        if (r_next == ST_IDLE) r_in_ready <= 1'b1;
                    end
                end

                ST_ADV: begin
                    if (r_col < c_col_max) begin
                        r_col      <= r_col + 7'd1;
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_col   <= 7'd0;
                        r_state <= ST_NEWLINE;
                    end
                end

                // At the bottom row the cursor stays put; the screen moves.
                ST_NEWLINE: begin
                    if (r_row < c_row_max) begin
                        r_row      <= r_row + 5'd1;
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state    <= ST_SCROLL;
                        r_req      <= w_scroll_req;
                        r_wr_start <= 1'b1;
                    end
                end

                // Unused encodings recover through the full start-up path.
                default: begin
                    r_state    <= ST_INIT;
                    r_wait_cnt <= '0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_start   = r_wr_start;
    assign wr_begin   = r_req.first;
    assign wr_end     = r_req.last;
    assign wr_data    = r_req.data;
    assign wr_offset  = r_req.offset;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_term_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_term_ctrl
//  Purpose  : Self-checking bench for term_ctrl. Directed byte vectors push
//             hand-computed display requests into a queue; a monitor pops
//             and compares on every wr_start. A responder models the display
//             completing each request a few cycles later.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_term_ctrl;

    logic        clk100 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_start;
    logic [10:0] wr_begin;
    logic [10:0] wr_end;
    logic [7:0]  wr_data;
    logic [7:0]  wr_offset;
    logic        wr_complete;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    logic        resp_complete = 1'b0;
    logic        inj_complete = 1'b0;
    logic        resp_en = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [10:0] b;
        logic [10:0] e;
        logic [7:0]  d;
        logic [7:0]  o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    assign wr_complete = resp_complete | inj_complete;

    always #5 clk100 = ~clk100;

    term_ctrl dut (
        .clk100      (clk100),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_start    (wr_start),
        .wr_begin    (wr_begin),
        .wr_end      (wr_end),
        .wr_data     (wr_data),
        .wr_offset   (wr_offset),
        .wr_complete (wr_complete),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_req(input logic [10:0] b, input logic [10:0] e,
                            input logic [7:0] d, input logic [7:0] o);
        exp_t x;
        x.b = b; x.e = e; x.d = d; x.o = o;
        exp_q.push_back(x);
    endtask

    // Monitor: every wr_start must match the oldest expected request.
    // Fill index is only meaningful for fills (offset 0).
    initial forever begin
        @(negedge clk100);
        if (wr_start === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_request: got begin=%0d end=%0d data=0x%02h offset=%0d, expected none",
                         wr_begin, wr_end, wr_data, wr_offset);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_begin !== mon_e.b || wr_end !== mon_e.e || wr_offset !== mon_e.o ||
                    (mon_e.o == 8'd0 && wr_data !== mon_e.d)) begin
                    n_fail++;
                    $display("FAIL request: got begin=%0d end=%0d data=0x%02h offset=%0d, expected begin=%0d end=%0d data=0x%02h offset=%0d",
                             wr_begin, wr_end, wr_data, wr_offset, mon_e.b, mon_e.e, mon_e.d, mon_e.o);
                end
            end
        end
    end

    // Display model: completes each request three cycles after its start.
    initial forever begin
        @(negedge clk100);
        if (wr_start === 1'b1 && resp_en) begin
            repeat (3) @(posedge clk100);
            #1 resp_complete = 1'b1;
            @(posedge clk100);
            #1 resp_complete = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check(name, in_ready, 1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready("ready_before_send");
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input logic [10:0] addr);
        push_req(addr, addr + 11'd1, b + 8'd1, 8'd0);
        send(b);
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, cursor_col, col);
        check({name, "_row"}, cursor_row, row);
    endtask

    // Holds through the start-up wait and confirms the opening clear.
    task automatic init_sequence(input string name);
        logic bad = 1'b0;
        for (int i = 1; i <= 8191; i++) begin
            tick();
            if (wr_start !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
        end
        check({name, "_quiet"}, bad, 0);
        push_req(11'd0, 11'd2000, 8'h21, 8'd0);
        tick();
        check({name, "_clear_start"}, wr_start, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h51;
        repeat (3) tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 1);
        check("reset_wr_start", wr_start, 0);
        check("reset_wr_end", wr_end, 0);
        check("reset_wr_data", wr_data, 0);
        check_cursor("reset_cursor", 0, 0);
        rst = 1'b0;

        // Start-up: 8192 quiet cycles despite in_valid, then full clear.
        init_sequence("init");
        in_valid = 1'b0;
        wait_ready("init_ready");
        check("init_busy", busy, 0);
        check_cursor("init_cursor", 0, 0);

        // 'A' at (0,0); request in the cycle after acceptance.
        put(8'h41, 11'd0);
        check("put_latency", wr_start, 1);
        check("put_ready_low", in_ready, 0);
        wait_ready("put_done");
        check_cursor("after_A", 1, 0);

        // Move to (0,3), then fill to column 79.
        repeat (3) send(8'h0A);
        send(8'h0D);
        wait_ready("lf_done");
        check_cursor("row3_start", 0, 3);
        for (int i = 0; i < 79; i++) put(8'h21 + 8'(i), 11'd240 + 11'(i));
        wait_ready("fill_done");
        check_cursor("at_79_3", 79, 3);

        // Last column wraps to the next row without scrolling.
        put(8'h7A, 11'd319);
        wait_ready("wrap_done");
        check_cursor("wrap", 0, 4);

        // Down to the bottom row, put one char, then CR + LF scrolls.
        repeat (20) send(8'h0A);
        wait_ready("to_bottom");
        check_cursor("bottom", 0, 24);
        put(8'h42, 11'd1920);
        wait_ready("bottom_put");
        check_cursor("bottom_put", 1, 24);
        send(8'h0D);
        check("cr_ready_stays", in_ready, 1);
        check_cursor("after_cr", 0, 24);
        push_req(11'd0, 11'd1920, 8'h21, 8'd80);
        push_req(11'd1920, 11'd2000, 8'h21, 8'd0);
        send(8'h0A);
        wait_ready("scroll_done");
        check_cursor("after_scroll", 0, 24);

        // BS at column 0 and an unknown code: no request, no motion.
        send(8'h08);
        check("bs_ready_stays", in_ready, 1);
        check_cursor("bs_col0", 0, 24);
        send(8'h07);
        check("bel_ready_stays", in_ready, 1);
        check_cursor("bel", 0, 24);

        // Stray complete pulse while idle.
        inj_complete = 1'b1;
        tick();
        inj_complete = 1'b0;
        tick();
        check("stray_ready", in_ready, 1);
        check("stray_busy", busy, 0);
        check_cursor("stray", 0, 24);

        // BS from column 1 steps back without erasing.
        put(8'h43, 11'd1920);
        wait_ready("bs_put");
        send(8'h08);
        check_cursor("bs_back", 0, 24);

        // Form feed clears and homes the cursor.
        push_req(11'd0, 11'd2000, 8'h21, 8'd0);
        send(8'h0C);
        wait_ready("ff_done");
        check_cursor("after_ff", 0, 0);

        // Reset in the middle of a clear's WAIT restarts the whole start-up.
        put(8'h44, 11'd0);
        wait_ready("pre_rst_put");
        resp_en = 1'b0;
        push_req(11'd0, 11'd2000, 8'h21, 8'd0);
        send(8'h0C);
        check("ff_start", wr_start, 1);
        repeat (5) tick();
        check("wait_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_en = 1'b1;
        check("rst_busy", busy, 1);
        check("rst_in_ready", in_ready, 0);
        check_cursor("rst_cursor", 0, 0);
        init_sequence("reinit");
        wait_ready("reinit_ready");
        check_cursor("reinit_cursor", 0, 0);

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
